// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - signal bundle between a measured source and clk_period_meter
interface clk_period_meter_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             timeout;

    modport master (
        output enable,
        output sig_in,
        input  period,
        input  high_time,
        input  valid,
        input  timeout
    );

    modport slave (
        input  enable,
        input  sig_in,
        output period,
        output high_time,
        output valid,
        output timeout
    );
endinterface

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period / high-time meter for a slow asynchronous square wave
module clk_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000000
) (
    input  logic                  in_clk,
    input  logic                  reset,
    clk_period_meter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [WIDTH-1:0] TO_LIMIT = WIDTH'(TIMEOUT);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_s;
    logic                   sig_d;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       hcnt;
    logic [WIDTH-1:0]       hshadow;
    logic [WIDTH-1:0]       cnt_inc;
    logic [WIDTH-1:0]       hcnt_inc;

    assign sig_s    = sync[SYNC_STAGES-1];
    assign cnt_inc  = cnt + WIDTH'(1);
    assign hcnt_inc = hcnt + WIDTH'(1);

    // Edge flags are registered so a rise captured at edge k is acted on at k+SYNC_STAGES+1.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            sync  <= '0;
            sig_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            sig_d <= sig_s;
            rise  <= sig_s & ~sig_d;
            fall  <= ~sig_s & sig_d;
        end
    end

    always_ff @(posedge in_clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            hcnt          <= '0;
            hshadow       <= '0;
            bus.period    <= '0;
            bus.high_time <= '0;
            bus.valid     <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (!bus.enable) begin
                state       <= IDLE;
                cnt         <= '0;
                hcnt        <= '0;
                hshadow     <= '0;
                bus.timeout <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        hcnt  <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        // cnt only feeds the timeout here; no result is produced until MEASURE.
                        if (rise) begin
                            cnt   <= '0;
                            hcnt  <= '0;
                            state <= MEASURE;
                        end else if (cnt_inc == TO_LIMIT) begin
                            bus.timeout <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            bus.period    <= cnt_inc;
                            bus.high_time <= hshadow;
                            bus.valid     <= 1'b1;
                            bus.timeout   <= 1'b0;
                            cnt           <= '0;
                            hcnt          <= '0;
                        end else begin
                            if (fall) begin
                                hshadow <= hcnt_inc;
                            end
                            if (cnt_inc == TO_LIMIT) begin
                                bus.timeout <= 1'b1;
                                cnt         <= '0;
                                hcnt        <= '0;
                                state       <= ARM;
                            end else begin
                                cnt  <= cnt_inc;
                                hcnt <= hcnt_inc;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
